// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO write-side logic.
package fifo_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int STAT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } skid_occ_t;

endpackage

// File: rtl/fifo_sat_counter.sv
// Statistics counter that stops at all-ones instead of wrapping.
module fifo_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_C = {WIDTH{1'b1}};

  // count up on inc until saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != MAX_C)) begin
      count <= count + ONE_C;
    end
  end

endmodule

// File: rtl/fifo_wr_ingress.sv
// Write-side ingress adapter: valid/ready stream into FIFO write strobe through a
// 2-entry skid buffer, with saturating accept/stall statistics.
module fifo_wr_ingress
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = STAT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0]  accept_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [1:0]            occupancy
);

  skid_occ_t             r_occ;
  skid_occ_t             w_occ_nxt;
  logic                  r_rdy_en;
  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_stall;

  // s_ready depends only on flops and flush, never on full or s_valid
  assign s_ready   = r_rdy_en & (r_occ != OCC_TWO) & ~flush;
  assign w_push    = s_valid & s_ready;
  assign w_pop     = (r_occ != OCC_EMPTY) & ~full & ~flush;
  assign w_stall   = (r_occ != OCC_EMPTY) & full & ~flush;
  assign wr_en     = w_pop;
  assign wr_data   = r_entry0;
  assign occupancy = r_occ;

  // ready enable comes up one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= OCC_EMPTY;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  // occupancy next state; flush wins over push/pop
  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: w_occ_nxt = w_push ? OCC_ONE : OCC_EMPTY;
        OCC_ONE: begin
          if (w_push && !w_pop) begin
            w_occ_nxt = OCC_TWO;
          end else if (!w_push && w_pop) begin
            w_occ_nxt = OCC_EMPTY;
          end else begin
            w_occ_nxt = OCC_ONE;
          end
        end
        OCC_TWO:   w_occ_nxt = w_pop ? OCC_ONE : OCC_TWO;
        default:   w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  // skid entries: entry0 is the head; a push lands in whichever slot frees up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else if (!flush) begin
      case (r_occ)
        OCC_EMPTY: if (w_push) r_entry0 <= s_data;
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_entry0 <= s_data;
          end else if (w_push) begin
            r_entry1 <= s_data;
          end
        end
        OCC_TWO:   if (w_pop) r_entry0 <= r_entry1;
        default: begin
          r_entry0 <= r_entry0;
          r_entry1 <= r_entry1;
        end
      endcase
    end
  end

  fifo_sat_counter #(.WIDTH(CNT_WIDTH)) u_accept_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_push),
    .count (accept_cnt)
  );

  fifo_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed, table-driven bench for fifo_wr_ingress plus hand-written saturation checks.
module tb_fifo_wr_ingress;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        full = 1'b0;
  logic        s_ready, wr_en;
  logic [7:0]  wr_data;
  logic [15:0] accept_cnt, stall_cnt;
  logic [1:0]  occupancy;
  logic        s_ready4, wr_en4;
  logic [7:0]  wr_data4;
  logic [3:0]  accept_cnt4, stall_cnt4;
  logic [1:0]  occupancy4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fifo_wr_ingress u_dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .full(full), .wr_en(wr_en), .wr_data(wr_data),
    .accept_cnt(accept_cnt), .stall_cnt(stall_cnt), .occupancy(occupancy)
  );

  fifo_wr_ingress #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .full(full), .wr_en(wr_en4), .wr_data(wr_data4),
    .accept_cnt(accept_cnt4), .stall_cnt(stall_cnt4), .occupancy(occupancy4)
  );

  typedef struct {
    logic        rst, flush, valid;
    logic [7:0]  data;
    logic        full;
    logic        rdy, wen;
    logic [7:0]  wd;
    logic [1:0]  occ;
    logic [15:0] acc, stall;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic v, input logic [7:0] d,
                     input logic fu, input logic rdy, input logic wen, input logic [7:0] wd,
                     input logic [1:0] occ, input logic [15:0] acc, input logic [15:0] st);
    vec_t e;
    e.rst = r; e.flush = f; e.valid = v; e.data = d; e.full = fu;
    e.rdy = rdy; e.wen = wen; e.wd = wd; e.occ = occ; e.acc = acc; e.stall = st;
    vq.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s vec%0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  initial begin
    rst = 1'b1;

    // reset held three cycles with a producer already valid
    for (int i = 0; i < 3; i++)
      add(1'b1,1'b0,1'b1,8'h55,1'b0, 1'b0,1'b0,8'h00,2'd0,16'd0,16'd0);
    add(1'b0,1'b0,1'b1,8'h55,1'b0, 1'b0,1'b0,8'h00,2'd0,16'd0,16'd0);
    // streaming 0x01..0x10 with one-cycle latency
    for (int k = 1; k <= 16; k++)
      add(1'b0,1'b0,1'b1,8'(k),1'b0, 1'b1,(k > 1),(k == 1) ? 8'h00 : 8'(k-1),
          (k == 1) ? 2'd0 : 2'd1, 16'(k-1), 16'd0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'h10,2'd1,16'd16,16'd0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h10,2'd0,16'd16,16'd0);
    // backpressure: full for five cycles
    add(1'b0,1'b0,1'b1,8'h20,1'b0, 1'b1,1'b0,8'h10,2'd0,16'd16,16'd0);
    add(1'b0,1'b0,1'b1,8'h21,1'b1, 1'b1,1'b0,8'h20,2'd1,16'd17,16'd0);
    for (int s = 1; s <= 4; s++)
      add(1'b0,1'b0,1'b1,8'h22,1'b1, 1'b0,1'b0,8'h20,2'd2,16'd18,16'(s));
    add(1'b0,1'b0,1'b1,8'h22,1'b0, 1'b0,1'b1,8'h20,2'd2,16'd18,16'd5);
    add(1'b0,1'b0,1'b1,8'h22,1'b0, 1'b1,1'b1,8'h21,2'd1,16'd18,16'd5);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'h22,2'd1,16'd19,16'd5);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h22,2'd0,16'd19,16'd5);
    // flush with 0xAA, 0xBB buffered; 0xCC must be the next word written
    add(1'b0,1'b0,1'b1,8'hAA,1'b1, 1'b1,1'b0,8'h22,2'd0,16'd19,16'd5);
    add(1'b0,1'b0,1'b1,8'hBB,1'b1, 1'b1,1'b0,8'hAA,2'd1,16'd20,16'd5);
    add(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'hAA,2'd2,16'd21,16'd6);
    add(1'b0,1'b0,1'b1,8'hCC,1'b0, 1'b1,1'b0,8'hAA,2'd0,16'd21,16'd6);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'hCC,2'd1,16'd22,16'd6);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'hCC,2'd0,16'd22,16'd6);
    // async reset with two words buffered: outputs clear before any clock edge
    add(1'b0,1'b0,1'b1,8'h31,1'b1, 1'b1,1'b0,8'hCC,2'd0,16'd22,16'd6);
    add(1'b0,1'b0,1'b1,8'h32,1'b1, 1'b1,1'b0,8'h31,2'd1,16'd23,16'd6);
    add(1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,2'd0,16'd0,16'd0);
    add(1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,2'd0,16'd0,16'd0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,2'd0,16'd0,16'd0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,2'd0,16'd0,16'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; flush = vq[i].flush; s_valid = vq[i].valid;
      s_data = vq[i].data; full = vq[i].full;
      #1;
      n_vec++;
      chk("s_ready",    i, {15'd0, s_ready},    {15'd0, vq[i].rdy});
      chk("wr_en",      i, {15'd0, wr_en},      {15'd0, vq[i].wen});
      chk("wr_data",    i, {8'd0, wr_data},     {8'd0, vq[i].wd});
      chk("occupancy",  i, {14'd0, occupancy},  {14'd0, vq[i].occ});
      chk("accept_cnt", i, accept_cnt,          vq[i].acc);
      chk("stall_cnt",  i, stall_cnt,           vq[i].stall);
    end

    // saturation: 20 back-to-back pushes into the 4-bit-counter instance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'(8'h40 + i); full = 1'b0;
      #1;
      n_vec++;
      chk("sat_ready4", i, {15'd0, s_ready4}, 16'd1);
      chk("sat_wr_en4", i, {15'd0, wr_en4}, {15'd0, (i > 0)});
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_vec++;
    chk("sat_acc4", 0, {12'd0, accept_cnt4}, 16'd15);
    chk("sat_acc16", 0, accept_cnt, 16'd20);
    chk("sat_last_data", 0, {8'd0, wr_data}, 16'h0053);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h60;
    #1;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_vec++;
    chk("sat_hold4", 1, {12'd0, accept_cnt4}, 16'd15);
    chk("sat_acc16b", 1, accept_cnt, 16'd21);
    chk("sat_stall4", 1, {12'd0, stall_cnt4}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
